// File: rtl/cve2_data_sram_bridge.sv
// Bridges the core data req/gnt/rvalid interface to a single-port SRAM.
// It adds grant wait states, flags accesses outside the SRAM window and counts errors.
module cve2_data_sram_bridge #(
  parameter logic [31:0] AddrBase   = 32'h0001_0000,
  parameter int unsigned MemWords   = 1024,
  parameter int unsigned WaitStates = 0,
  parameter bit          OutReg     = 1'b0,
  localparam int unsigned AW        = $clog2(MemWords)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          data_req_i,
  output logic          data_gnt_o,
  output logic          data_rvalid_o,
  input  logic          data_we_i,
  input  logic [3:0]    data_be_i,
  input  logic [31:0]   data_addr_i,
  input  logic [31:0]   data_wdata_i,
  output logic [31:0]   data_rdata_o,
  output logic          data_err_o,
  output logic          sram_req_o,
  output logic          sram_we_o,
  output logic [AW-1:0] sram_addr_o,
  output logic [31:0]   sram_wdata_o,
  output logic [31:0]   sram_wmask_o,
  input  logic [31:0]   sram_rdata_i,
  output logic [15:0]   err_cnt_o
);

  localparam logic [31:0] WinMask  = ~(32'(MemWords * 4) - 32'd1);
  localparam logic [2:0]  WaitInit =
    (WaitStates > 0) ? 3'(WaitStates - 1) : 3'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        lat_q, lat_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q;
  logic [15:0] err_cnt_q;
  logic        gnt, rvalid, accept, in_win;

  assign in_win = (data_addr_i & WinMask) == AddrBase;

  // With OutReg the first RESP cycle only captures the SRAM data.
  assign rvalid = (state_q == RESP) && (!OutReg || lat_q);
  assign accept = (state_q == IDLE) || rvalid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    we_d    = we_q;
    err_d   = err_q;
    gnt     = 1'b0;
    unique case (1'b1)
      accept: begin
        state_d = IDLE;
        if (data_req_i) begin
          if (WaitStates == 0) begin
            gnt = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WaitInit;
          end
        end
      end
      (state_q == WAIT): begin
        if (!data_req_i) begin
          state_d = IDLE;
        end else if (cnt_q == 3'd0) begin
          gnt = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: lat_d = 1'b1;
    endcase
    if (gnt) begin
      state_d = RESP;
      lat_d   = 1'b0;
      we_d    = data_we_i;
      err_d   = !in_win;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      lat_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (OutReg && state_q == RESP && !lat_q) begin
      rdata_q <= sram_rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q <= '0;
    end else if (rvalid && err_q && err_cnt_q != 16'hFFFF) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  // Grant is held off while reset is asserted.
  assign data_gnt_o    = gnt && rst_ni;
  assign sram_req_o    = data_gnt_o && in_win;
  assign sram_we_o     = sram_req_o && data_we_i;
  assign sram_addr_o   = sram_req_o ? data_addr_i[2 +: AW] : '0;
  assign sram_wdata_o  = sram_we_o ? data_wdata_i : '0;

  always_comb begin
    sram_wmask_o = '0;
    for (int i = 0; i < 4; i++) begin
      sram_wmask_o[8*i +: 8] = {8{sram_we_o & data_be_i[i]}};
    end
  end

  assign data_rvalid_o = rvalid;
  assign data_err_o    = rvalid && err_q;
  assign data_rdata_o  = (rvalid && !we_q && !err_q) ?
                         (OutReg ? rdata_q : sram_rdata_i) : '0;
  assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_cve2_data_sram_bridge.sv
// Scoreboard bench for cve2_data_sram_bridge.
// Three instances: plain, OutReg=1, WaitStates=3.
module tb_cve2_data_sram_bridge;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]        req, we, gnt, rvalid, err, sreq, swe;
  logic [2:0][3:0]   be;
  logic [2:0][31:0]  addr, wdata, rdata, swdata, smask, srdata;
  logic [2:0][9:0]   saddr;
  logic [2:0][15:0]  ecnt;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int unsigned c;
  } exp_t;

  exp_t sb [3][$];
  exp_t mon_e;
  logic [31:0] mem [3][1024];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    cve2_data_sram_bridge #(
      .AddrBase  (32'h0001_0000),
      .MemWords  (1024),
      .WaitStates((g == 2) ? 3 : 0),
      .OutReg    (g == 1)
    ) u_dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .data_req_i   (req[g]),
      .data_gnt_o   (gnt[g]),
      .data_rvalid_o(rvalid[g]),
      .data_we_i    (we[g]),
      .data_be_i    (be[g]),
      .data_addr_i  (addr[g]),
      .data_wdata_i (wdata[g]),
      .data_rdata_o (rdata[g]),
      .data_err_o   (err[g]),
      .sram_req_o   (sreq[g]),
      .sram_we_o    (swe[g]),
      .sram_addr_o  (saddr[g]),
      .sram_wdata_o (swdata[g]),
      .sram_wmask_o (smask[g]),
      .sram_rdata_i (srdata[g]),
      .err_cnt_o    (ecnt[g])
    );
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (sreq[g]) begin
        if (swe[g])
          mem[g][saddr[g]] <= (mem[g][saddr[g]] & ~smask[g]) |
                              (swdata[g] & smask[g]);
        else
          srdata[g] <= mem[g][saddr[g]];
      end
    end
  end

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (rvalid[g]) begin
        if (sb[g].size() == 0) begin
          chk($sformatf("dut%0d_spurious_rvalid", g), 32'd1, 32'd0);
        end else begin
          mon_e = sb[g].pop_front();
          chk($sformatf("dut%0d_rdata", g), rdata[g], mon_e.d);
          chk($sformatf("dut%0d_err", g), 32'(err[g]), 32'(mon_e.e));
          chk($sformatf("dut%0d_latency", g), cyc, mon_e.c);
        end
      end
    end
  end

  task automatic chk_zero(int g);
    chk($sformatf("dut%0d_rst_gnt", g), 32'(gnt[g]), 0);
    chk($sformatf("dut%0d_rst_rvalid", g), 32'(rvalid[g]), 0);
    chk($sformatf("dut%0d_rst_err", g), 32'(err[g]), 0);
    chk($sformatf("dut%0d_rst_rdata", g), rdata[g], 0);
    chk($sformatf("dut%0d_rst_sreq", g), 32'(sreq[g]), 0);
    chk($sformatf("dut%0d_rst_swe", g), 32'(swe[g]), 0);
    chk($sformatf("dut%0d_rst_saddr", g), 32'(saddr[g]), 0);
    chk($sformatf("dut%0d_rst_swdata", g), swdata[g], 0);
    chk($sformatf("dut%0d_rst_smask", g), smask[g], 0);
    chk($sformatf("dut%0d_rst_errcnt", g), 32'(ecnt[g]), 0);
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic xfer(int g, logic w, logic [3:0] b, logic [31:0] a,
                      logic [31:0] d, logic [31:0] er, logic ee,
                      int gw, logic [31:0] emask, int rv);
    int n = 0;
    exp_t x;
    logic [31:0] ea;
    req[g] = 1'b1;
    we[g] = w;
    be[g] = b;
    addr[g] = a;
    wdata[g] = d;
    @(negedge clk);
    while (!gnt[g] && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk($sformatf("dut%0d_gnt_wait_%h", g, a), n, gw);
    if (gnt[g]) begin
      ea = {22'd0, a[11:2]};
      chk($sformatf("dut%0d_sreq_%h", g, a), 32'(sreq[g]), ee ? 0 : 1);
      chk($sformatf("dut%0d_swe_%h", g, a), 32'(swe[g]), 32'(w && !ee));
      chk($sformatf("dut%0d_smask_%h", g, a), smask[g], emask);
      chk($sformatf("dut%0d_swdata_%h", g, a), swdata[g],
          (w && !ee) ? d : 32'd0);
      if (!ee) chk($sformatf("dut%0d_saddr_%h", g, a), 32'(saddr[g]), ea);
      if (rv >= 0)
        chk($sformatf("dut%0d_rv_with_gnt", g), 32'(rvalid[g]), rv);
      x.d = er;
      x.e = ee;
      x.c = cyc + 1 + ((g == 1) ? 1 : 0);
      sb[g].push_back(x);
    end
    @(posedge clk);
    #1;
    req[g] = 1'b0;
    we[g] = 1'b0;
    be[g] = '0;
    addr[g] = '0;
    wdata[g] = '0;
  endtask

  task automatic drain(int g);
    int n = 0;
    while (sb[g].size() != 0 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk($sformatf("dut%0d_drain", g), sb[g].size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    req = '0;
    we = '0;
    be = '0;
    addr = '0;
    wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) chk_zero(g);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // Plain instance: write, read, byte mask, out of window.
    xfer(0, 1, 4'hF, 32'h0001_0010, 32'hDEAD_BEEF,
         32'h0, 0, 0, 32'hFFFF_FFFF, 0);
    drain(0);
    xfer(0, 0, 4'hF, 32'h0001_0010, 32'h0,
         32'hDEAD_BEEF, 0, 0, 32'h0, 0);
    drain(0);
    xfer(0, 1, 4'b0101, 32'h0001_0012, 32'h1122_3344,
         32'h0, 0, 0, 32'h00FF_00FF, 0);
    drain(0);
    xfer(0, 0, 4'hF, 32'h0001_0010, 32'h0,
         32'hDE22_BE44, 0, 0, 32'h0, 0);
    drain(0);
    xfer(0, 0, 4'hF, 32'h0000_FFFC, 32'h0,
         32'h0, 1, 0, 32'h0, 0);
    xfer(0, 1, 4'hF, 32'h0001_1000, 32'hAAAA_5555,
         32'h0, 1, 0, 32'h0, 1);
    drain(0);
    chk("dut0_err_cnt", 32'(ecnt[0]), 2);

    // Back-to-back: each grant lands on the previous rvalid.
    xfer(0, 0, 4'hF, 32'h0001_0010, 32'h0,
         32'hDE22_BE44, 0, 0, 32'h0, 0);
    xfer(0, 1, 4'hF, 32'h0001_0014, 32'h1234_5678,
         32'h0, 0, 0, 32'hFFFF_FFFF, 1);
    xfer(0, 0, 4'hF, 32'h0001_0014, 32'h0,
         32'h1234_5678, 0, 0, 32'h0, 1);
    xfer(0, 0, 4'hF, 32'h0001_0010, 32'h0,
         32'hDE22_BE44, 0, 0, 32'h0, 1);
    drain(0);

    // Registered output instance.
    xfer(1, 1, 4'hF, 32'h0001_0010, 32'hDEAD_BEEF,
         32'h0, 0, 0, 32'hFFFF_FFFF, 0);
    drain(1);
    xfer(1, 0, 4'hF, 32'h0001_0010, 32'h0,
         32'hDEAD_BEEF, 0, 0, 32'h0, 0);
    drain(1);
    xfer(1, 0, 4'hF, 32'h0001_2000, 32'h0,
         32'h0, 1, 0, 32'h0, 0);
    drain(1);
    chk("dut1_err_cnt", 32'(ecnt[1]), 1);

    // Wait-state instance: aborted request, then normal traffic.
    req[2] = 1'b1;
    addr[2] = 32'h0001_0020;
    repeat (2) begin
      @(negedge clk);
      chk("dut2_abort_no_gnt", 32'(gnt[2]), 0);
    end
    @(posedge clk);
    #1;
    req[2] = 1'b0;
    @(negedge clk);
    chk("dut2_abort_idle_gnt", 32'(gnt[2]), 0);
    @(posedge clk);
    #1;
    xfer(2, 1, 4'hF, 32'h0001_0020, 32'hCAFE_F00D,
         32'h0, 0, 3, 32'hFFFF_FFFF, 0);
    drain(2);
    xfer(2, 0, 4'hF, 32'h0001_0020, 32'h0,
         32'hCAFE_F00D, 0, 3, 32'h0, 0);
    drain(2);

    // Reset in the grant cycle of a read.
    req[0] = 1'b1;
    we[0] = 1'b0;
    be[0] = 4'hF;
    addr[0] = 32'h0001_0010;
    @(negedge clk);
    chk("dut0_pre_reset_gnt", 32'(gnt[0]), 1);
    rst_ni = 1'b0;
    req[0] = 1'b0;
    addr[0] = '0;
    #1;
    chk_zero(0);
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("dut0_no_rvalid_after_reset", 32'(rvalid[0]), 0);
    end
    @(posedge clk);
    #1;
    xfer(0, 0, 4'hF, 32'h0001_0010, 32'h0,
         32'hDE22_BE44, 0, 0, 32'h0, 0);
    drain(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
